// File: rtl/ahb_sram_responder_if.sv
// AHB-Lite bus bundle between one manager stream and the SRAM responder.
//   master modport: drives select, address-phase controls, HREADY and HWDATA;
//                   receives HRDATA, HREADYOUT and HRESP.
//   slave modport : the mirror image, used by ahb_sram_responder.
// HREADY is the bus-wide ready returned by the interconnect, so it is
// driven from the manager/interconnect side.
interface ahb_sram_responder_if #(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned XLEN    = 64
);
  logic               HSEL;
  logic [PA_BITS-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [2:0]         HBURST;
  logic               HREADY;
  logic [XLEN-1:0]    HWDATA;
  logic [XLEN-1:0]    HRDATA;
  logic               HREADYOUT;
  logic               HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder backed by a local register-array memory.
// Decodes size/alignment/range at the address phase, inserts WAIT_STATES
// low cycles before each OKAY completion, performs byte-lane writes and
// returns the two-cycle ERROR response for illegal transfers.
// Ports:
//   HCLK    - clock
//   HRESETn - asynchronous active-low reset
//   bus     - AHB-Lite slave modport (HSEL, HADDR, HTRANS, HWRITE, HSIZE,
//             HBURST, HREADY, HWDATA in; HRDATA, HREADYOUT, HRESP out)
module ahb_sram_responder #(
  parameter int unsigned     PA_BITS     = 32,
  parameter int unsigned     XLEN        = 64,
  parameter longint unsigned BASE        = 64'h8000_0000,
  parameter int unsigned     DEPTH_WORDS = 64,
  parameter int unsigned     WAIT_STATES = 1
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb_sram_responder_if.slave bus
);

  localparam int unsigned LANES  = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // One extra bit so the end-of-region bound cannot wrap.
  localparam logic [PA_BITS:0] BASE_X  = (PA_BITS + 1)'(BASE);
  localparam logic [PA_BITS:0] LIMIT_X = (PA_BITS + 1)'(BASE + 64'(DEPTH_WORDS * LANES));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state, state_d;
  logic [3:0]          wait_cnt;
  logic [IDX_W-1:0]    idx_q;
  logic [LANE_W-1:0]   lane_q;
  logic [2:0]          size_q;
  logic                write_q;

  logic [XLEN-1:0]     mem [DEPTH_WORDS];

  // HBURST and HTRANS[0] carry no meaning here: every beat is independent.
  logic unused_ctrl;
  assign unused_ctrl = ^{bus.HBURST, bus.HTRANS[0]};

  // ---------------- address-phase decode ----------------
  logic [PA_BITS:0]   addr_x;
  logic [PA_BITS-1:0] offset;
  logic               out_of_range, oversize, misaligned, req_err;
  logic [IDX_W-1:0]   idx_d;
  logic [LANE_W-1:0]  lane_d;

  assign addr_x       = {1'b0, bus.HADDR};
  assign out_of_range = (addr_x < BASE_X) || (addr_x >= LIMIT_X);
  assign oversize     = bus.HSIZE > 3'(LANE_W);
  assign misaligned   = |(bus.HADDR[6:0] & 7'((8'd1 << bus.HSIZE) - 8'd1));
  assign req_err      = out_of_range | oversize | misaligned;

  assign offset = bus.HADDR - PA_BITS'(BASE);
  assign idx_d  = IDX_W'(offset >> LANE_W);
  assign lane_d = LANE_W'(bus.HADDR);

  // A new address phase can only be taken while this responder is ready.
  logic can_accept, accept;
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = can_accept & bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  // ---------------- state register ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        wait_cnt <= 4'(WAIT_STATES);
        idx_q    <= idx_d;
        lane_q   <= lane_d;
        size_q   <= bus.HSIZE;
        write_q  <= bus.HWRITE;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // ---------------- next state / outputs ----------------
  logic ready_o, resp_o;

  always_comb begin
    state_d = state;
    ready_o = 1'b1;
    resp_o  = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        resp_o = (state == ST_ERR2);
        if (accept) begin
          if (req_err)
            state_d = ST_ERR1;
          else if (WAIT_STATES != 0)
            state_d = ST_WAIT;
          else
            state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ready_o = 1'b0;
        if (wait_cnt == 4'd1)
          state_d = ST_DATA;
      end
      ST_ERR1: begin
        ready_o = 1'b0;
        resp_o  = 1'b1;
        state_d = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.HREADYOUT = ready_o;
  assign bus.HRESP     = resp_o;
  assign bus.HRDATA    = (state == ST_DATA && !write_q) ? mem[idx_q] : '0;

  // ---------------- byte-lane write ----------------
  logic [LANES-1:0] lane_en;

  always_comb begin
    lane_en = '0;
    for (int unsigned b = 0; b < LANES; b++)
      lane_en[b] = (b >= 32'(lane_q)) && (b < 32'(lane_q) + (32'd1 << size_q));
  end

  // Array is not reset; it commits on the edge that leaves DATA.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && write_q) begin
      for (int unsigned b = 0; b < LANES; b++)
        if (lane_en[b])
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
  end

endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
AHB-Lite subordinate (responder) that services the arbitrated manager stream leaving the EBU. It is backed by a local register-array memory with a configurable wait-state count. It decodes transfer size and alignment, generates byte-lane writes, and returns the two-cycle ERROR response for illegal transfers. It is used as the standard on-chip RAM/peripheral endpoint and as a bench target for the manager-side arbitration logic.

Parameters:
PA_BITS, 32, physical address width.
XLEN, 64, data bus width (32 or 64).
BASE, 0x8000_0000, byte base address of the region.
DEPTH_WORDS, 64, number of XLEN-wide words in the array.
WAIT_STATES, 1, wait cycles inserted before each OKAY completion; range 0..15.

Ports:
HCLK  in  1  clock.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  decoder select for this responder.
HADDR  in  PA_BITS  address-phase address.
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HWRITE  in  1  1 write, 0 read.
HSIZE  in  3  transfer size, log2 bytes.
HBURST  in  3  burst type; accepted but not used for decode.
HREADY  in  1  bus-wide ready; a high value ends the current data phase.
HWDATA  in  XLEN  write data, valid in the data phase.
HRDATA  out  XLEN  read data.
HREADYOUT  out  1  this responder's ready.
HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset is async: HRESETn low forces state IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0. This applies even mid-WAIT or mid-ERR. Array contents are not reset.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled on the rising edge of HCLK. On accept, register addr, write, size and the error flag.
- IDLE/BUSY transfers, or any cycle with HSEL=0, are never accepted. They receive the zero-wait OKAY response (HREADYOUT=1, HRESP=0).
- The error flag is set when any of these holds:
  - address < BASE;
  - address >= BASE + DEPTH_WORDS*XLEN/8;
  - HSIZE > log2(XLEN/8);
  - HADDR is not aligned to 2^HSIZE.
- FSM states IDLE, WAIT, DATA, ERR1, ERR2:
  - IDLE: HREADYOUT=1, HRESP=0. On accept, go to ERR1 if error; else WAIT if WAIT_STATES>0; else DATA.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES on accept and decrements each cycle. At counter==1, go to DATA. This gives exactly WAIT_STATES low cycles.
  - DATA: HREADYOUT=1, HRESP=0, completion cycle. Exit follows the IDLE rules (pipelined back-to-back accept allowed); otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Exit follows the IDLE rules.
- Latency: each accepted OKAY transfer takes WAIT_STATES+1 data-phase cycles; each ERROR takes 2.
- Write commit: on the rising edge that ends DATA for a write, HWDATA updates only the enabled byte lanes.
  - Lanes are 2^size bytes starting at addr[log2(XLEN/8)-1:0].
  - Word index = (addr-BASE) >> log2(XLEN/8).
- Read: in DATA for a read, HRDATA = array[word index], full word with all lanes driven. It is combinational from the registered index, so a write completing on the previous edge is visible.
- HRDATA=0 in every state other than DATA-read.
- Errored transfers never modify the array. HRDATA=0 during ERR1/ERR2.
- HREADY low while in IDLE/DATA/ERR2 (another responder stalling): no accept, and no state change other than DATA/ERR2 going to IDLE.
- HBURST is ignored; each beat is handled as an independent transfer, with no address prediction.

Test Plan:
1. WAIT_STATES=2, write HSIZE=3 data 0x1122334455667788 to BASE+0x8, then read it back → HREADYOUT low exactly 2 cycles on each transfer, HRESP=0, and HRDATA=0x1122334455667788 in the read completion cycle.
2. Byte write HSIZE=0 to BASE+0xB with lane 3=0xAB, then doubleword read of BASE+0x8 → HRDATA=0x11223344AB667788.
3. WAIT_STATES=0, write then read BASE+0x10 back-to-back in pipelined NONSEQ beats → no HREADYOUT low cycle, and the read returns the just-written value.
4. Read at BASE+DEPTH_WORDS*8; misaligned HSIZE=2 at BASE+0x2; HSIZE=4 → each gives (HREADYOUT,HRESP) = (0,1) then (1,1), HRDATA=0, and the array is unchanged on re-read.
5. HSEL=1 with NONSEQ while HREADY=0; IDLE/BUSY transfers with HREADY=1 → no accept, HREADYOUT stays 1, HRESP stays 0.
6. Assert HRESETn=0 mid-WAIT and mid-ERR1 → HREADYOUT=1, HRESP=0, HRDATA=0 before the next clock edge. The next NONSEQ after release completes normally.
